// File: rtl/arbitro_salida_pkg.sv
// Shared definitions for the output arbiter: FSM encoding and default widths.
package arbitro_salida_pkg;

    localparam int TAMANO_DATOS_DEF = 12;
    localparam int NUM_FIFOS_DEF    = 4;
    localparam int CNT_W_DEF        = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_PAUSE  = 2'd2
    } estado_t;

endpackage

// File: rtl/arbitro_salida_rr_grant.sv
// Combinational 4-way round-robin priority: the search begins just after the
// previous winner and the first requester found is granted (one-hot).
module rr_grant (
    input  logic [3:0] request,
    input  logic [1:0] last_grant,
    output logic [3:0] grant
);

    logic [1:0] cand;
    logic       found;

    // Walk the four positions starting at last_grant+1; offset 4 wraps back to last_grant.
    always_comb begin
        grant = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_grant + k[1:0];
            if (!found && request[cand]) begin
                grant[cand] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_salida.sv
// Output arbiter: round-robin drains four show-ahead FIFOs into one registered
// stream, keeps a per-FIFO transfer counter and serves counter reads.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | all FIFOs empty and no pause seen; idle_out high
// ST_ACTIVE | at least one FIFO non-empty, forwarding words
// ST_PAUSE  | downstream almost-full; no grants issued
module arbitro_salida
    import arbitro_salida_pkg::*;
#(
    parameter int TAMANO_DATOS = TAMANO_DATOS_DEF,
    parameter int NUM_FIFOS    = NUM_FIFOS_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_FIFOS-1:0]    fifo_empty,
    input  logic [TAMANO_DATOS-1:0] data_in0,
    input  logic [TAMANO_DATOS-1:0] data_in1,
    input  logic [TAMANO_DATOS-1:0] data_in2,
    input  logic [TAMANO_DATOS-1:0] data_in3,
    input  logic                    pause,
    output logic [NUM_FIFOS-1:0]    pop,
    output logic [TAMANO_DATOS-1:0] data_out,
    output logic                    push_out,
    output logic                    idle_out,
    input  logic                    req,
    input  logic [1:0]              idx,
    output logic                    cnt_valid,
    output logic [CNT_W-1:0]        cnt_out
);

    estado_t                 state_q, state_d;
    logic [1:0]              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]        cnt_q [NUM_FIFOS];
    logic [CNT_W-1:0]        cnt_d [NUM_FIFOS];
    logic [TAMANO_DATOS-1:0] data_out_q, data_out_d;
    logic                    push_q, push_d;
    logic                    cnt_valid_q, cnt_valid_d;
    logic [CNT_W-1:0]        cnt_out_q, cnt_out_d;

    logic [3:0]              grant;
    logic [1:0]              win_idx;
    logic                    pop_any;
    logic                    all_empty;
    logic [TAMANO_DATOS-1:0] win_data;

    rr_grant u_rr_grant (
        .request    (~fifo_empty),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    // Pop gating looks at the live pause/reset inputs, not the state register,
    // so a pause or reset blocks the grant in the very same cycle.
    always_comb begin
        pop       = (reset || pause) ? '0 : grant;
        pop_any   = |pop;
        all_empty = &fifo_empty;
        win_idx   = '0;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            if (pop[i]) win_idx = 2'(i);
        end
        case (win_idx)
            2'd0:    win_data = data_in0;
            2'd1:    win_data = data_in1;
            2'd2:    win_data = data_in2;
            default: win_data = data_in3;
        endcase
    end

    // Next-state: FSM transitions, grant pointer, counters, output stream and counter reads.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (pause)           state_d = ST_PAUSE;
                else if (!all_empty) state_d = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (pause)          state_d = ST_PAUSE;
                else if (all_empty) state_d = ST_IDLE;
            end
            ST_PAUSE: begin
                if (!pause) state_d = all_empty ? ST_IDLE : ST_ACTIVE;
            end
            default: state_d = ST_IDLE;
        endcase

        last_grant_d = pop_any ? win_idx : last_grant_q;
        for (int i = 0; i < NUM_FIFOS; i++) begin
            cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, pop[i]};
        end
        data_out_d  = pop_any ? win_data : data_out_q;
        push_d      = pop_any;
        cnt_valid_d = req;
        cnt_out_d   = req ? cnt_q[idx] : cnt_out_q;
    end

    // Register update with synchronous reset; the grant pointer resets to 3 so FIFO 0 wins first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 2'd3;
            for (int i = 0; i < NUM_FIFOS; i++) cnt_q[i] <= '0;
            data_out_q   <= '0;
            push_q       <= 1'b0;
            cnt_valid_q  <= 1'b0;
            cnt_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            for (int i = 0; i < NUM_FIFOS; i++) cnt_q[i] <= cnt_d[i];
            data_out_q   <= data_out_d;
            push_q       <= push_d;
            cnt_valid_q  <= cnt_valid_d;
            cnt_out_q    <= cnt_out_d;
        end
    end

    assign data_out  = data_out_q;
    assign push_out  = push_q;
    assign idle_out  = (state_q == ST_IDLE);
    assign cnt_valid = cnt_valid_q;
    assign cnt_out   = cnt_out_q;

endmodule

// File: tb/tb_arbitro_salida.sv
// Self-checking bench for arbitro_salida: directed scenarios plus random
// traffic, compared against a behavioural model of the arbitration rules.
module tb_arbitro_salida;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  fifo_empty;
    logic [11:0] data_in0, data_in1, data_in2, data_in3;
    logic        pause;
    logic [3:0]  pop;
    logic [11:0] data_out;
    logic        push_out;
    logic        idle_out;
    logic        req;
    logic [1:0]  idx;
    logic        cnt_valid;
    logic [4:0]  cnt_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state (plain integers)
    int m_last;
    int m_cnt [4];
    int m_data, m_push, m_cv, m_co;
    int m_idle;

    arbitro_salida dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .data_in0   (data_in0),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .data_in3   (data_in3),
        .pause      (pause),
        .pop        (pop),
        .data_out   (data_out),
        .push_out   (push_out),
        .idle_out   (idle_out),
        .req        (req),
        .idx        (idx),
        .cnt_valid  (cnt_valid),
        .cnt_out    (cnt_out)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check pop, advance model, check registered outputs.
    task automatic step(input bit rst, input logic [3:0] fe, input bit pa,
                        input bit rq, input logic [1:0] ix, input logic [11:0] d0);
        int g;
        int word [4];
        int exp_pop;
        reset      = rst;
        fifo_empty = fe;
        pause      = pa;
        req        = rq;
        idx        = ix;
        data_in0   = d0;
        data_in1   = 12'($urandom);
        data_in2   = 12'($urandom);
        data_in3   = 12'($urandom);
        word[0] = int'(data_in0); word[1] = int'(data_in1);
        word[2] = int'(data_in2); word[3] = int'(data_in3);
        #1;
        g = -1;
        if (!rst && !pa) begin
            for (int k = 1; k <= 4; k++) begin
                if (g < 0 && fe[(m_last + k) % 4] == 1'b0) g = (m_last + k) % 4;
            end
        end
        exp_pop = (g >= 0) ? (1 << g) : 0;
        check_val("pop", 32'(pop), 32'(exp_pop));

        if (rst) begin
            m_last = 3;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_data = 0; m_push = 0; m_cv = 0; m_co = 0; m_idle = 1;
        end else begin
            if (rq) begin
                m_cv = 1;
                m_co = m_cnt[ix];
            end else begin
                m_cv = 0;
            end
            if (g >= 0) begin
                m_data   = word[g];
                m_push   = 1;
                m_cnt[g] = (m_cnt[g] + 1) % 32;
                m_last   = g;
            end else begin
                m_push = 0;
            end
            // Next state depends only on this cycle's pause and emptiness.
            m_idle = (!pa && fe == 4'b1111) ? 1 : 0;
        end

        @(posedge clk);
        #1;
        check_val("data_out",  32'(data_out),  32'(m_data));
        check_val("push_out",  32'(push_out),  32'(m_push));
        check_val("cnt_valid", 32'(cnt_valid), 32'(m_cv));
        check_val("cnt_out",   32'(cnt_out),   32'(m_co));
        check_val("idle_out",  32'(idle_out),  32'(m_idle));
    endtask

    initial begin
        reset = 1'b1; fifo_empty = 4'hF; pause = 1'b0; req = 1'b0; idx = 2'd0;
        data_in0 = '0; data_in1 = '0; data_in2 = '0; data_in3 = '0;

        // Reset state
        step(1, 4'b1111, 0, 0, 0, 12'h000);
        check_val("rst_idle", 32'(idle_out), 32'd1);
        check_val("rst_push", 32'(push_out), 32'd0);

        // Single FIFO 0 word
        step(0, 4'b1110, 0, 0, 0, 12'h4A4);
        check_val("single_data", 32'(data_out), 32'h4A4);
        check_val("single_push", 32'(push_out), 32'd1);
        step(0, 4'b1111, 0, 1, 0, 12'h000);
        check_val("single_cnt0", 32'(cnt_out), 32'd1);

        // Four-FIFO rotation for 8 cycles, then read every counter
        step(1, 4'b1111, 0, 0, 0, 12'h000);
        for (int c = 0; c < 8; c++) begin
            step(0, 4'b0000, 0, 0, 0, 12'($urandom));
            check_val("rotation_push", 32'(push_out), 32'd1);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b1111, 0, 1, 2'(i), 12'h000);
            check_val("rotation_cnt", 32'(cnt_out), 32'd2);
        end

        // Pause in cycles 3..5 of continuous traffic
        step(1, 4'b1111, 0, 0, 0, 12'h000);
        for (int c = 0; c < 10; c++) begin
            step(0, 4'b0000, (c >= 3 && c <= 5), 0, 0, 12'($urandom));
            if (c >= 3 && c <= 5) check_val("pause_push", 32'(push_out), 32'd0);
        end

        // Counter wrap on FIFO 1 after 33 pops
        step(1, 4'b1111, 0, 0, 0, 12'h000);
        for (int c = 0; c < 33; c++) step(0, 4'b1101, 0, 0, 0, 12'h000);
        step(0, 4'b1111, 0, 1, 2'd1, 12'h000);
        check_val("wrap_valid", 32'(cnt_valid), 32'd1);
        check_val("wrap_cnt1",  32'(cnt_out),   32'd1);

        // Read coinciding with a pop returns the pre-increment value
        step(1, 4'b1111, 0, 0, 0, 12'h000);
        for (int c = 0; c < 6; c++) step(0, 4'b1011, 0, 0, 0, 12'h000);
        step(0, 4'b1011, 0, 1, 2'd2, 12'h000);
        check_val("same_edge_cnt2", 32'(cnt_out), 32'd6);
        step(0, 4'b1111, 0, 1, 2'd2, 12'h000);
        check_val("after_edge_cnt2", 32'(cnt_out), 32'd7);

        // Reset in the middle of a burst
        for (int c = 0; c < 5; c++) step(0, 4'b0000, 0, 0, 0, 12'($urandom));
        step(1, 4'b0000, 0, 0, 0, 12'h000);
        check_val("midrst_push", 32'(push_out), 32'd0);
        check_val("midrst_idle", 32'(idle_out), 32'd1);
        reset = 1'b0; fifo_empty = 4'b0000; pause = 1'b0; req = 1'b0;
        #1;
        check_val("midrst_first_grant", 32'(pop), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b1111, 0, 1, 2'(i), 12'h000);
            check_val("midrst_cnt", 32'(cnt_out), 32'd0);
        end

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 99) < 2),
                 4'($urandom) | 4'($urandom),
                 ($urandom_range(0, 99) < 20),
                 1'($urandom),
                 2'($urandom),
                 12'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
